clock_mode_ctrl: RTL
====================

Name: clock_mode_ctrl

Overview:
Controller that sequences the time-keeping counter datapath of the electronic clock. It generates the 1 Hz advance enable and runs the manual set-mode FSM (hour/minute/second field select and increment). It also arbitrates time loads between the local buttons and the Bluetooth receiver. It drives a single load strobe with hour/minute/second values into the counter and reports the current mode to the VGA display path.

Parameters:
TICK_DIV, 100_000_000, CLK_100M cycles per 1 Hz tick; benches override with a small value such as 10.
SYNC_STAGES, 2, synchroniser depth for button inputs.

Ports:
CLK_100M  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
ena  in  1  global enable; low freezes time and forces RUN
btn_change  in  1  debounced level, enter/leave set mode
btn_switch  in  1  debounced level, next field
btn_inc  in  1  debounced level, increment selected field
cur_hour  in  5  live hour from the counter
cur_minute  in  6  live minute from the counter
cur_second  in  6  live second from the counter
bt_valid  in  1  Bluetooth time-set request valid
bt_hour  in  5  requested hour
bt_minute  in  6  requested minute
bt_second  in  6  requested second
bt_ready  out  1  request accepted when bt_valid && bt_ready
bt_err  out  1  one-cycle pulse, out-of-range request rejected
tick_1hz  out  1  one-cycle advance enable to the counter
run_en  out  1  counter may advance
load  out  1  one-cycle load strobe
load_hour  out  5  value loaded with load
load_minute  out  6  value loaded with load
load_second  out  6  value loaded with load
mode  out  2  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
edit_hour  out  5  edit register for display during set
edit_minute  out  6  edit register for display during set
edit_second  out  6  edit register for display during set

Behaviour:
- Reset: state RUN; tick counter 0. bt_ready, bt_err, tick_1hz, load: 0. load_* and edit_*: 0. mode: 0. Synchroniser and edge flops: 0. run_en: 0 in the reset cycle, then follows ena.
- Buttons: SYNC_STAGES flops, then a rising-edge detect. The edge pulse is high for one cycle, SYNC_STAGES+1 cycles after the input rises. Held levels produce no further pulses.
- Tick: counter runs 0..TICK_DIV-1 only when state==RUN and ena==1. tick_1hz=1 in the cycle the counter wraps from TICK_DIV-1 to 0. The counter is cleared on any load and while not running.
- FSM:
  - RUN, change edge: edit_* <= cur_*; go to SET_H.
  - SET_H, switch edge: go to SET_M. SET_M, switch edge: go to SET_S. SET_S, switch edge: go to SET_H.
  - SET_x, inc edge: selected field +1. Hour wraps 23->0; minute and second wrap 59->0.
  - SET_x, change edge: next cycle load=1 with load_*=edit_*; go to RUN.
- Same-cycle button edges in a SET state: change has priority over switch, and switch has priority over inc. Lower-priority edges in that cycle are dropped.
- Bluetooth handshake:
  - bt_ready is registered: 1 iff the next state is RUN and ena=1.
  - On handshake, validate hour<=23, minute<=59, second<=59.
  - Valid request: load=1 on the next cycle with the bt values.
  - Invalid request: bt_err=1 on the next cycle and no load.
- If a handshake and a change edge occur in the same RUN cycle, Bluetooth wins and the change edge is dropped.
- ena=0: state is forced to RUN. run_en=0, bt_ready=0, no tick. All edges are ignored. edit_* are retained. A pending load already registered still issues.
- Mid-operation rst: returns to RUN immediately, and no load is issued.
- mode mirrors the state register (registered, no combinational path).

Decomposition:
- clock_pkg holds:
  - the state enum (RUN, SET_H, SET_M, SET_S);
  - MAX_HOUR=23 and MAX_MIN_SEC=59;
  - HOUR_W=5 and MS_W=6.
- Sub-module btn_edge_sync (parameter SYNC_STAGES; ports CLK_100M, rst, din, rise) is instantiated three times.

Test Plan:
- Reset, then ena=1 with TICK_DIV=10 -> tick_1hz pulses every 10 cycles. No load. bt_ready=1 from the 2nd cycle.
- cur=12:34:56, change pulse -> mode=1 and edit=12:34:56. Two inc -> edit_hour=14. Switch, then inc 26 times -> minute wraps 59->0 and ends at 0. Change -> one load with 14:00:56, then mode=0.
- SET_H with edit_hour=23, inc -> 0. SET_S with edit_second=59, inc -> 0. Three switch pulses from SET_H -> SET_H.
- bt_valid with 25:10:10 -> bt_err pulse and no load. bt_valid with 08:15:30 -> load with 08:15:30 on the next cycle, and the tick counter restarts (first tick 10 cycles later).
- bt handshake and change edge in the same cycle -> load with bt values; mode stays 0.
- In SET_M: ena dropped -> mode=0, run_en=0, no ticks, bt_ready=0. rst asserted mid-SET_S -> mode=0, edit=0, no load.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, field limits and helper functions for the electronic clock
// controller.
package clock_pkg;

   localparam int HOUR_W = 5;
   localparam int MS_W   = 6;

   localparam logic [HOUR_W-1:0] MAX_HOUR    = 5'd23;
   localparam logic [MS_W-1:0]   MAX_MIN_SEC = 6'd59;

   // Encoding is visible on the mode output, so values are pinned.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   // Hour field increment with 23 -> 0 wrap.
   function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] v);
      return (v >= MAX_HOUR) ? '0 : v + 5'd1;
   endfunction

   // Minute/second field increment with 59 -> 0 wrap.
   function automatic logic [MS_W-1:0] inc_min_sec(input logic [MS_W-1:0] v);
      return (v >= MAX_MIN_SEC) ? '0 : v + 6'd1;
   endfunction

   // A remote time-set request is only honoured when every field is in range.
   function automatic logic time_in_range(input logic [HOUR_W-1:0] h,
                                          input logic [MS_W-1:0]   m,
                                          input logic [MS_W-1:0]   s);
      return (h <= MAX_HOUR) && (m <= MAX_MIN_SEC) && (s <= MAX_MIN_SEC);
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchronises a debounced button level into the clock domain and emits a
// registered one-cycle pulse on each rising edge.
module btn_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK_100M,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;
   logic                   rise_q;

   // Synchroniser chain, previous-level flop and registered edge pulse.
   always_ff @(posedge CLK_100M) begin
      if (rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage samples its neighbour's old value;
         // blocking assignments would collapse the chain into one flop.
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         last_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode controller for the electronic clock: 1 Hz advance enable, manual
// set-mode FSM with edit registers, and arbitration of time loads between
// the local buttons and the Bluetooth receiver.
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV    = 100_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK_100M,
   input  logic              rst,
   input  logic              ena,
   input  logic              btn_change,
   input  logic              btn_switch,
   input  logic              btn_inc,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MS_W-1:0]   cur_minute,
   input  logic [MS_W-1:0]   cur_second,
   input  logic              bt_valid,
   input  logic [HOUR_W-1:0] bt_hour,
   input  logic [MS_W-1:0]   bt_minute,
   input  logic [MS_W-1:0]   bt_second,
   output logic              bt_ready,
   output logic              bt_err,
   output logic              tick_1hz,
   output logic              run_en,
   output logic              load,
   output logic [HOUR_W-1:0] load_hour,
   output logic [MS_W-1:0]   load_minute,
   output logic [MS_W-1:0]   load_second,
   output logic [1:0]        mode,
   output logic [HOUR_W-1:0] edit_hour,
   output logic [MS_W-1:0]   edit_minute,
   output logic [MS_W-1:0]   edit_second
);

   localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick_q, tick_d;
   logic              load_q, load_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;
   logic              run_en_q;
   logic [HOUR_W-1:0] load_hour_q, load_hour_d, edit_hour_q, edit_hour_d;
   logic [MS_W-1:0]   load_min_q, load_min_d, edit_min_q, edit_min_d;
   logic [MS_W-1:0]   load_sec_q, load_sec_d, edit_sec_q, edit_sec_d;

   logic ch_rise, sw_rise, inc_rise;
   logic ch_e, sw_e, inc_e;
   logic hs, bt_ok;

   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_change (
      .CLK_100M (CLK_100M), .rst (rst), .din (btn_change), .rise (ch_rise)
   );
   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_switch (
      .CLK_100M (CLK_100M), .rst (rst), .din (btn_switch), .rise (sw_rise)
   );
   btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
      .CLK_100M (CLK_100M), .rst (rst), .din (btn_inc), .rise (inc_rise)
   );

   // Buttons are ignored entirely while the clock is disabled.
   assign ch_e  = ch_rise  & ena;
   assign sw_e  = sw_rise  & ena;
   assign inc_e = inc_rise & ena;

   // ready_q is only ever high while state_q is RUN, so a handshake can only
   // occur in RUN; it pre-empts any same-cycle change edge.
   assign hs    = bt_valid & ready_q;
   assign bt_ok = time_in_range(bt_hour, bt_minute, bt_second);

   // State register.
   always_ff @(posedge CLK_100M) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next-state logic: change beats switch; disabling forces RUN.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      if (!ena) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:     if (ch_e && !hs) state_d = SET_H;
            SET_H:   if (ch_e) state_d = RUN; else if (sw_e) state_d = SET_M;
            SET_M:   if (ch_e) state_d = RUN; else if (sw_e) state_d = SET_S;
            SET_S:   if (ch_e) state_d = RUN; else if (sw_e) state_d = SET_H;
            default: state_d = RUN;
         endcase
      end
   end

   // Output/datapath next values: loads, reject pulse, edit fields, tick.
   always_comb begin
      load_d      = 1'b0;
      err_d       = 1'b0;
      load_hour_d = load_hour_q;
      load_min_d  = load_min_q;
      load_sec_d  = load_sec_q;
      edit_hour_d = edit_hour_q;
      edit_min_d  = edit_min_q;
      edit_sec_d  = edit_sec_q;

      if (hs) begin
         if (bt_ok) begin
            load_d      = 1'b1;
            load_hour_d = bt_hour;
            load_min_d  = bt_minute;
            load_sec_d  = bt_second;
         end else begin
            err_d = 1'b1;
         end
      end else if (state_q == RUN) begin
         if (ch_e) begin
            edit_hour_d = cur_hour;
            edit_min_d  = cur_minute;
            edit_sec_d  = cur_second;
         end
      end else if (ch_e) begin
         load_d      = 1'b1;
         load_hour_d = edit_hour_q;
         load_min_d  = edit_min_q;
         load_sec_d  = edit_sec_q;
      end else if (!sw_e && inc_e) begin
         case (state_q)
            SET_H:   edit_hour_d = inc_hour(edit_hour_q);
            SET_M:   edit_min_d  = inc_min_sec(edit_min_q);
            SET_S:   edit_sec_d  = inc_min_sec(edit_sec_q);
            default: ;
         endcase
      end

      ready_d = (state_d == RUN) && ena;

      // The divider restarts on every load so the first second after a
      // time set is a full second.
      tick_d = 1'b0;
      if (load_d || (state_q != RUN) || !ena) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Datapath and registered-output flops.
   always_ff @(posedge CLK_100M) begin
      if (rst) begin
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         load_q      <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         run_en_q    <= 1'b0;
         load_hour_q <= '0;
         load_min_q  <= '0;
         load_sec_q  <= '0;
         edit_hour_q <= '0;
         edit_min_q  <= '0;
         edit_sec_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         load_q      <= load_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         run_en_q    <= ena;
         load_hour_q <= load_hour_d;
         load_min_q  <= load_min_d;
         load_sec_q  <= load_sec_d;
         edit_hour_q <= edit_hour_d;
         edit_min_q  <= edit_min_d;
         edit_sec_q  <= edit_sec_d;
      end
   end

   assign bt_ready    = ready_q;
   assign bt_err      = err_q;
   assign tick_1hz    = tick_q;
   assign run_en      = run_en_q;
   assign load        = load_q;
   assign load_hour   = load_hour_q;
   assign load_minute = load_min_q;
   assign load_second = load_sec_q;
   assign mode        = state_q;
   assign edit_hour   = edit_hour_q;
   assign edit_minute = edit_min_q;
   assign edit_second = edit_sec_q;

endmodule
